// File: rtl/reset_pkg.sv
// Shared types and constants for the reset generator/sequencer.
// Cause bit positions match the layout of rst_cause_o: {por, ext, wdt, sw}.
package reset_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } rst_seq_state_e;

  localparam int CAUSE_SW    = 0;
  localparam int CAUSE_WDT   = 1;
  localparam int CAUSE_EXT   = 2;
  localparam int CAUSE_POR   = 3;
  localparam int RST_CAUSE_W = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_gen_seq.sv
// Reset generator/sequencer: merges reset requests, holds all domains in reset, then releases them
// in index order with a fixed stagger. Sticky cause tracking is built only when RST_CAUSE_EN is defined.
module reset_gen_seq
  import reset_pkg::*;
#(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n_i,
  input  logic                   sw_rst_req_i,
  input  logic                   wdt_rst_req_i,
  input  logic                   ext_rst_req_i,
  input  logic                   rst_cause_clr_i,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   rst_req_ack_o,
  output logic                   rst_busy_o,
  output logic                   rst_done_o,
  output logic [RST_CAUSE_W-1:0] rst_cause_o
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGGER_CYCLES) + 1);
  localparam int IDX_W = $clog2(NUM_DOMAINS + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST  = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_DONE   = IDX_W'(NUM_DOMAINS);

  rst_seq_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [NUM_DOMAINS-1:0] rst_n_d;
  logic                   ack_d;
  logic                   busy_d;
  logic                   done_d;

  logic req_any;
  assign req_any = sw_rst_req_i | wdt_rst_req_i | ext_rst_req_i;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // idx runs one past the last domain so the final stagger completes before RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (req_any) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (idx_q == IDX_DONE) begin
            state_d = RUN;
            cnt_d   = '0;
          end else if (cnt_q == STAG_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN:     ;
        default: state_d = HOLD;
      endcase
    end
  end

  always_comb begin
    rst_n_d = rst_n_o;
    busy_d  = rst_busy_o;
    done_d  = rst_done_o;
    ack_d   = req_any;
    if (req_any) begin
      rst_n_d = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          rst_n_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
        RELEASE: begin
          if (idx_q == IDX_DONE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else if (cnt_q == '0) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (idx_q == IDX_W'(i)) rst_n_d[i] = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rst_n_o       <= '0;
      rst_req_ack_o <= 1'b0;
      rst_busy_o    <= 1'b1;
      rst_done_o    <= 1'b0;
    end else begin
      rst_n_o       <= rst_n_d;
      rst_req_ack_o <= ack_d;
      rst_busy_o    <= busy_d;
      rst_done_o    <= done_d;
    end
  end

`ifdef RST_CAUSE_EN
  logic [RST_CAUSE_W-1:0] cause_q;
  logic [RST_CAUSE_W-1:0] cause_set;

  // A request in the same cycle as a clear keeps its own bit.
  always_comb begin
    cause_set            = '0;
    cause_set[CAUSE_SW]  = sw_rst_req_i;
    cause_set[CAUSE_WDT] = wdt_rst_req_i;
    cause_set[CAUSE_EXT] = ext_rst_req_i;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cause_q            <= '0;
      cause_q[CAUSE_POR] <= 1'b1;
    end else if (rst_cause_clr_i) begin
      cause_q <= cause_set;
    end else begin
      cause_q <= cause_q | cause_set;
    end
  end

  assign rst_cause_o = cause_q;
`else
  logic unused_cause_clr;
  assign unused_cause_clr = rst_cause_clr_i;
  assign rst_cause_o      = '0;
`endif

endmodule

// File: tb/tb_reset_gen_seq.sv
// Directed bench for reset_gen_seq with default parameters; cause checks follow RST_CAUSE_EN.
// Edges are counted from the release of rst_n_i or from the edge that accepted a request.
module tb_reset_gen_seq;

  logic       clk;
  logic       rst_n_i;
  logic       sw_rst_req_i;
  logic       wdt_rst_req_i;
  logic       ext_rst_req_i;
  logic       rst_cause_clr_i;
  logic [3:0] rst_n_o;
  logic       rst_req_ack_o;
  logic       rst_busy_o;
  logic       rst_done_o;
  logic [3:0] rst_cause_o;

  int n_cmp;
  int n_err;
  int ec;

  reset_gen_seq dut (
    .clk             (clk),
    .rst_n_i         (rst_n_i),
    .sw_rst_req_i    (sw_rst_req_i),
    .wdt_rst_req_i   (wdt_rst_req_i),
    .ext_rst_req_i   (ext_rst_req_i),
    .rst_cause_clr_i (rst_cause_clr_i),
    .rst_n_o         (rst_n_o),
    .rst_req_ack_o   (rst_req_ack_o),
    .rst_busy_o      (rst_busy_o),
    .rst_done_o      (rst_done_o),
    .rst_cause_o     (rst_cause_o)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (edge %0d)", tag, got, exp, ec);
    end
  endtask

  task automatic chk_cause(input string tag, input logic [3:0] exp);
`ifdef RST_CAUSE_EN
    chk(tag, 32'(rst_cause_o), 32'(exp));
`else
    chk(tag, 32'(rst_cause_o), 32'h0);
`endif
  endtask

  // advance to edge `target`, then settle 1 time unit past it
  task automatic goto_edge(input int target);
    while (ec < target) begin
      @(posedge clk);
      ec++;
    end
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] rn, input logic busy, input logic done);
    chk({tag, "_rst_n"}, 32'(rst_n_o), 32'(rn));
    chk({tag, "_busy"}, 32'(rst_busy_o), 32'(busy));
    chk({tag, "_done"}, 32'(rst_done_o), 32'(done));
  endtask

  task automatic chk_release(input string tag, input int e0);
    goto_edge(e0 + 16); chk_outs({tag, "_e16"}, 4'h0, 1'b1, 1'b0);
    goto_edge(e0 + 17); chk_outs({tag, "_e17"}, 4'h1, 1'b1, 1'b0);
    goto_edge(e0 + 24); chk({tag, "_e24"}, 32'(rst_n_o), 32'h1);
    goto_edge(e0 + 25); chk({tag, "_e25"}, 32'(rst_n_o), 32'h3);
    goto_edge(e0 + 33); chk({tag, "_e33"}, 32'(rst_n_o), 32'h7);
    goto_edge(e0 + 41); chk_outs({tag, "_e41"}, 4'hf, 1'b1, 1'b0);
    goto_edge(e0 + 48); chk_outs({tag, "_e48"}, 4'hf, 1'b1, 1'b0);
    goto_edge(e0 + 49); chk_outs({tag, "_e49"}, 4'hf, 1'b0, 1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ec    = 0;
    rst_n_i         = 1'b0;
    sw_rst_req_i    = 1'b0;
    wdt_rst_req_i   = 1'b0;
    ext_rst_req_i   = 1'b0;
    rst_cause_clr_i = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    chk_outs("rst", 4'h0, 1'b1, 1'b0);
    chk("rst_ack", 32'(rst_req_ack_o), 32'h0);
    chk_cause("rst_cause", 4'b1000);
    rst_n_i = 1'b1;
    ec = 0;

    // power-on sequence
    chk_release("por", 0);
    chk_cause("por_cause", 4'b1000);

    // 1-cycle sw request in RUN, accepted at edge 50
    sw_rst_req_i = 1'b1;
    goto_edge(50);
    chk_outs("sw_acc", 4'h0, 1'b1, 1'b0);
    chk("sw_ack", 32'(rst_req_ack_o), 32'h1);
    chk_cause("sw_cause", 4'b1001);
    sw_rst_req_i = 1'b0;
    goto_edge(51);
    chk("sw_ack_drop", 32'(rst_req_ack_o), 32'h0);
    goto_edge(66); chk("sw_e16", 32'(rst_n_o), 32'h0);
    goto_edge(67); chk("sw_e17", 32'(rst_n_o), 32'h1);
    goto_edge(75); chk("sw_e25", 32'(rst_n_o), 32'h3);

    // wdt pulse with domains 0-1 released, accepted at edge 81
    goto_edge(80);
    wdt_rst_req_i = 1'b1;
    goto_edge(81);
    chk_outs("wdt_acc", 4'h0, 1'b1, 1'b0);
    chk("wdt_ack", 32'(rst_req_ack_o), 32'h1);
    chk_cause("wdt_cause", 4'b1011);
    wdt_rst_req_i = 1'b0;
    chk_release("wdt", 81);

    // clear causes, then ext held for 40 accepting edges (131+1 .. 171)
    rst_cause_clr_i = 1'b1;
    goto_edge(131);
    chk_cause("clr_cause", 4'b0000);
    rst_cause_clr_i = 1'b0;
    ext_rst_req_i = 1'b1;
    goto_edge(132); chk_outs("ext_132", 4'h0, 1'b1, 1'b0);
    chk("ext_ack_132", 32'(rst_req_ack_o), 32'h1);
    goto_edge(155); chk_outs("ext_155", 4'h0, 1'b1, 1'b0);
    goto_edge(171); chk_outs("ext_171", 4'h0, 1'b1, 1'b0);
    chk("ext_ack_171", 32'(rst_req_ack_o), 32'h1);
    chk_cause("ext_cause", 4'b0100);
    ext_rst_req_i = 1'b0;
    goto_edge(172); chk("ext_ack_drop", 32'(rst_req_ack_o), 32'h0);
    goto_edge(187); chk("ext_e16", 32'(rst_n_o), 32'h0);
    goto_edge(188); chk("ext_e17", 32'(rst_n_o), 32'h1);

    // clear together with sw request: sw bit survives
    rst_cause_clr_i = 1'b1;
    sw_rst_req_i    = 1'b1;
    goto_edge(189);
    chk_cause("clr_sw_cause", 4'b0001);
    chk("clr_sw_rst_n", 32'(rst_n_o), 32'h0);
    rst_cause_clr_i = 1'b0;
    sw_rst_req_i    = 1'b1;
    wdt_rst_req_i   = 1'b1;
    goto_edge(190);
    chk_cause("sw_wdt_cause", 4'b0011);
    chk("sw_wdt_ack", 32'(rst_req_ack_o), 32'h1);
    sw_rst_req_i  = 1'b0;
    wdt_rst_req_i = 1'b0;

    // asynchronous reset mid-sequence (3 domains released)
    goto_edge(225);
    chk("pre_async_rst_n", 32'(rst_n_o), 32'h7);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_outs("async", 4'h0, 1'b1, 1'b0);
    chk("async_ack", 32'(rst_req_ack_o), 32'h0);
    chk_cause("async_cause", 4'b1000);
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;
    ec = 0;
    chk_release("por2", 0);

    // simultaneous sw+wdt with POR bit still set, then clear
    sw_rst_req_i  = 1'b1;
    wdt_rst_req_i = 1'b1;
    goto_edge(50);
    chk_cause("sim_cause", 4'b1011);
    chk_outs("sim_acc", 4'h0, 1'b1, 1'b0);
    sw_rst_req_i    = 1'b0;
    wdt_rst_req_i   = 1'b0;
    rst_cause_clr_i = 1'b1;
    goto_edge(51);
    chk_cause("sim_clr_cause", 4'b0000);
    rst_cause_clr_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
